// File: rtl/axi_master_port.sv
// AXI4 master: turns one request into a read burst (1-16 beats) or a single-beat write, one outstanding at a time.
// Latency: accept N -> AxVALID N+1, rsp N+1 after R/B handshake; req_ready low while busy, AXI stalls simply hold state.
module axi_master_port #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [3:0]          req_len,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_rvalid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_done,
  output logic                rsp_err,
  output logic [3:0]          ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [3:0]          RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [3:0]          AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WADDR = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;

  logic [2:0]          state;
  logic                ready_en;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [4:0]          beat_cnt;
  logic                err_q;
  logic                aw_done;
  logic                w_done;

  logic accept, aw_hs, w_hs, beat_err;

  // ready_en keeps req_ready low during reset so every output reads 0 there
  assign req_ready = ready_en & (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign beat_err  = (RRESP != 2'b00) | (RID != MASTER_ID);

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = (state == S_RADDR);
  assign RREADY  = (state == S_RDATA);

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = (state == S_WADDR) & ~aw_done;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WVALID  = (state == S_WADDR) & ~w_done;
  assign WLAST   = WVALID;
  assign BREADY  = (state == S_WRESP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      ready_en   <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_rvalid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_done   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      rsp_rvalid <= 1'b0;
      rsp_done   <= 1'b0;
      rsp_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            len_q    <= req_len;
            wdata_q  <= req_wdata;
            wstrb_q  <= req_wstrb;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            state    <= req_write ? S_WADDR : S_RADDR;
          end
        end
        S_RADDR: begin
          if (ARREADY) state <= S_RDATA;
        end
        S_RDATA: begin
          if (RVALID) begin
            rsp_rdata  <= RDATA;
            rsp_rvalid <= 1'b1;
            // saturate so an overlong burst can never wrap back onto len
            if (beat_cnt != 5'h1f) beat_cnt <= beat_cnt + 5'd1;
            err_q <= err_q | beat_err;
            if (RLAST) begin
              state    <= S_IDLE;
              rsp_done <= 1'b1;
              rsp_err  <= err_q | beat_err | (beat_cnt != {1'b0, len_q});
            end
          end
        end
        S_WADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= S_WRESP;
        end
        S_WRESP: begin
          if (BVALID) begin
            state    <= S_IDLE;
            rsp_done <= 1'b1;
            rsp_err  <= (BRESP != 2'b00) | (BID != MASTER_ID);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_port.sv
`timescale 1ns/1ps
// Bench for axi_master_port: bench-side AXI slave, request driver, and a scoreboard monitor on the rsp_* port.
module tb_axi_master_port;

  localparam logic [3:0] MID = 4'd0;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_len, req_wstrb;
  logic        rsp_rvalid, rsp_done, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  ARID, ARLEN, RID, AWID, AWLEN, BID, WSTRB;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  always #5 ACLK = ~ACLK;

  axi_master_port #(.MASTER_ID(MID), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_rvalid(rsp_rvalid), .rsp_rdata(rsp_rdata), .rsp_done(rsp_done), .rsp_err(rsp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct packed { logic is_read; logic err; } done_t;

  int          checks = 0;
  int          passed = 0;
  int          ar_hs_cnt = 0;
  logic [31:0] exp_rdata_q[$];
  done_t       exp_done_q[$];

  // per-beat behaviour the bench slave will produce for the next read
  logic [31:0] bd[32];
  logic [1:0]  br[32];
  logic [3:0]  bi[32];
  int          bgap[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard monitor
  initial begin
    done_t d;
    forever begin
      @(negedge ACLK);
      if (ARVALID && ARREADY) ar_hs_cnt++;
      if (rsp_rvalid) begin
        if (exp_rdata_q.size() == 0) chk("unexpected_rvalid", rsp_rvalid, 0);
        else chk("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
      end
      if (rsp_done) begin
        if (exp_done_q.size() == 0) chk("unexpected_done", rsp_done, 0);
        else begin
          d = exp_done_q.pop_front();
          chk("rsp_err", rsp_err, d.err);
          chk("done_with_rvalid", rsp_rvalid, d.is_read);
          chk("ready_at_done", req_ready, 1);
        end
      end
    end
  end

  task automatic wait_empty();
    int k = 0;
    while ((exp_rdata_q.size() != 0 || exp_done_q.size() != 0) && k < 50) begin
      @(posedge ACLK);
      k++;
    end
    chk("scoreboard_drained", exp_rdata_q.size() + exp_done_q.size(), 0);
    @(posedge ACLK); #1;
  endtask

  // called just after a posedge; returns just after the accepting posedge
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                       input logic [31:0] wd, input logic [3:0] ws);
    int k = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    req_wdata = wd; req_wstrb = ws;
    @(negedge ACLK);
    while (!req_ready && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    chk("req_ready", req_ready, 1);
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    // scramble the request bus to prove the DUT latched it
    req_addr = $urandom; req_wdata = $urandom; req_len = 4'($urandom); req_wstrb = 4'($urandom);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input int nb, input int ar_dly);
    logic  e;
    done_t d;
    int    k, hs0;
    e = (nb != int'(len) + 1);
    for (int i = 0; i < nb; i++) begin
      exp_rdata_q.push_back(bd[i]);
      if (br[i] != 2'b00 || bi[i] != MID) e = 1'b1;
    end
    d.is_read = 1'b1; d.err = e;
    exp_done_q.push_back(d);
    hs0 = ar_hs_cnt;
    issue(1'b0, addr, len, 32'd0, 4'd0);
    k = 0;
    ARREADY = (ar_dly == 0);
    forever begin
      @(negedge ACLK);
      chk("arvalid", ARVALID, 1);
      chk("araddr", ARADDR, addr);
      chk("arlen", ARLEN, len);
      if (ARREADY || k > 40) break;
      @(posedge ACLK); #1;
      k++;
      ARREADY = (k >= ar_dly);
    end
    chk("ar_fields", {ARID, ARSIZE, ARBURST}, {MID, 3'b010, 2'b01});
    @(posedge ACLK); #1;
    ARREADY = 1'b0;
    chk("arvalid_drop", ARVALID, 0);
    chk("ar_hs_once", ar_hs_cnt - hs0, 1);
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < bgap[i]; g++) begin
        @(posedge ACLK); #1;
      end
      RVALID = 1'b1; RDATA = bd[i]; RRESP = br[i]; RID = bi[i]; RLAST = (i == nb - 1);
      @(negedge ACLK);
      chk("rready", RREADY, 1);
      @(posedge ACLK); #1;
      RVALID = 1'b0; RLAST = 1'b0; RDATA = $urandom;
      chk("rvalid_latency", rsp_rvalid, 1);
      chk("done_timing", rsp_done, (i == nb - 1));
    end
    wait_empty();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] bresp, input logic [3:0] bid);
    done_t d;
    logic  awt, wt;
    int    k;
    d.is_read = 1'b0; d.err = (bresp != 2'b00) || (bid != MID);
    exp_done_q.push_back(d);
    issue(1'b1, addr, 4'($urandom), wd, ws);
    k = 0; awt = 1'b0; wt = 1'b0;
    AWREADY = (aw_dly == 0); WREADY = (w_dly == 0);
    while (!(awt && wt) && k < 40) begin
      @(negedge ACLK);
      chk("awvalid", AWVALID, !awt);
      chk("wvalid", WVALID, !wt);
      chk("bready_early", BREADY, 0);
      if (!awt) chk("aw_fields", {AWADDR, AWLEN, AWSIZE, AWBURST, AWID}, {addr, 4'd0, 3'b010, 2'b01, MID});
      if (!wt)  chk("w_fields", {WDATA, WSTRB, WLAST}, {wd, ws, 1'b1});
      @(posedge ACLK); #1;
      if (AWREADY) awt = 1'b1;
      if (WREADY) wt = 1'b1;
      k++;
      AWREADY = !awt && (k >= aw_dly);
      WREADY  = !wt && (k >= w_dly);
    end
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("aw_w_handshakes", {awt, wt}, 2'b11);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge ACLK);
      chk("bready", BREADY, 1);
      @(posedge ACLK); #1;
    end
    BVALID = 1'b1; BRESP = bresp; BID = bid;
    @(negedge ACLK);
    chk("bready", BREADY, 1);
    chk("aw_w_idle_in_wresp", {AWVALID, WVALID}, 2'b00);
    @(posedge ACLK); #1;
    BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0;
    chk("bready_drop", BREADY, 0);
    chk("wdone_latency", rsp_done, 1);
    wait_empty();
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {req_ready, ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY,
               rsp_rvalid, rsp_done, rsp_err, rsp_rdata, ARADDR, ARLEN, WDATA, WSTRB},
        '0);
  endtask

  task automatic reset_test();
    done_t d;
    for (int i = 0; i < 4; i++) begin
      bd[i] = $urandom;
      exp_rdata_q.push_back(bd[i]);
    end
    d.is_read = 1'b1; d.err = 1'b0;
    exp_done_q.push_back(d);
    issue(1'b0, 32'h300, 4'd3, 32'd0, 4'd0);
    ARREADY = 1'b1;
    @(posedge ACLK); #1;
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = bd[0]; RRESP = 2'b00; RID = MID; RLAST = 1'b0;
    @(posedge ACLK); #1;
    RDATA = bd[1];
    #6;
    // second beat is on the bus but not yet taken
    ARESETn = 1'b0;
    #1;
    check_all_zero("reset_mid_read");
    exp_rdata_q.delete();
    exp_done_q.delete();
    RVALID = 1'b0; RDATA = 32'd0;
    repeat (3) begin
      @(negedge ACLK);
      chk("no_done_in_reset", rsp_done, 0);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
  endtask

  initial begin
    int          nb;
    logic [3:0]  len;
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_wdata = 0; req_wstrb = 0;
    ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
    repeat (2) @(posedge ACLK);
    #1;
    check_all_zero("reset_state");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    bd[0] = 32'hDEADBEEF; br[0] = 2'b00; bi[0] = MID; bgap[0] = 0;
    do_read(32'h0000_0010, 4'd0, 1, 0);

    for (int i = 0; i < 4; i++) begin
      bd[i] = i + 1; br[i] = 2'b00; bi[i] = MID; bgap[i] = (i == 2) ? 2 : 0;
    end
    do_read(32'h0000_0100, 4'd3, 4, 0);

    for (int i = 0; i < 2; i++) begin
      bd[i] = $urandom; br[i] = 2'b00; bi[i] = MID; bgap[i] = 0;
    end
    do_read(32'h0000_2000, 4'd1, 2, 5);

    do_write(32'h0000_0040, 32'h1234_5678, 4'b0011, 3, 1, 0, 2'b00, MID);
    do_write(32'h0000_0044, $urandom, 4'hF, 0, 0, 2, 2'b10, MID);

    for (int i = 0; i < 3; i++) begin
      bd[i] = $urandom; br[i] = 2'b00; bi[i] = MID; bgap[i] = 0;
    end
    do_read(32'h0000_0080, 4'd3, 3, 0);
    do_read(32'h0000_0090, 4'd0, 3, 1);

    reset_test();
    for (int i = 0; i < 4; i++) begin
      bd[i] = $urandom; br[i] = 2'b00; bi[i] = MID; bgap[i] = 0;
    end
    do_read(32'h0000_0400, 4'd3, 4, 0);

    repeat (40) begin
      if ($urandom_range(1, 0) == 1) begin
        len = 4'($urandom_range(15, 0));
        nb = int'(len) + 1;
        if ($urandom_range(7, 0) == 0) nb = $urandom_range(18, 1);
        for (int i = 0; i < nb; i++) begin
          bd[i]   = $urandom;
          br[i]   = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
          bi[i]   = ($urandom_range(19, 0) == 0) ? 4'($urandom_range(15, 1)) : MID;
          bgap[i] = $urandom_range(2, 0);
        end
        do_read($urandom & 32'hFFFF_FFFC, len, nb, $urandom_range(3, 0));
      end else begin
        do_write($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                 ($urandom_range(4, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                 ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 1)) : MID);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
